// File: rtl/bram_arbiter_pkg.sv
// bram_arbiter_pkg: shared state, grant and write-enable encodings for the bank arbiter.
package bram_arbiter_pkg;
    typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;
    typedef enum logic {GNT_A = 1'b0, GNT_B = 1'b1} gnt_t;
    localparam logic [3:0] WREN_ALL = 4'hF;
endpackage

// File: rtl/bram_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin arbiter; a conflict goes to the port not granted last.
module rr_arb2
    import bram_arbiter_pkg::*;
(
    input  logic CLK,
    input  logic RESETn,
    input  logic en,
    input  logic req_a,
    input  logic req_b,
    input  logic upd,
    output logic gnt_a,
    output logic gnt_b
);
    gnt_t last;
    always_ff @(posedge CLK or negedge RESETn)
        if (!RESETn) last <= GNT_B;
        else if (upd) last <= gnt_b ? GNT_B : GNT_A;
    always_comb begin
        gnt_a = en && req_a && (!req_b || last == GNT_B);
        gnt_b = en && req_b && (!req_a || last == GNT_A);
    end
endmodule

// File: rtl/bram_arbiter.sv
// bram_arbiter: shares one byte-writable 32-bit bank between a fetch port (A) and a load/store port (B),
// with an optional zero-fill of the bank after reset.
module bram_arbiter
    import bram_arbiter_pkg::*;
#(
    parameter int AW = 6,
    parameter bit CLEAR_ON_RESET = 1'b0
) (
    input  logic          CLK,
    input  logic          RESETn,
    input  logic          A_VALID,
    output logic          A_READY,
    input  logic [AW-3:0] A_ADDR,
    output logic          A_RVALID,
    output logic [31:0]   A_RDATA,
    input  logic          B_VALID,
    output logic          B_READY,
    input  logic          B_WRITE,
    input  logic [AW-3:0] B_ADDR,
    input  logic [31:0]   B_WDATA,
    input  logic [3:0]    B_WSTRB,
    output logic          B_RVALID,
    output logic [31:0]   B_RDATA,
    output logic [AW-3:0] M_ADDR,
    output logic [31:0]   M_WDATA,
    output logic [3:0]    M_WREN,
    input  logic [31:0]   M_RDATA,
    output logic          INIT_DONE
);
    localparam state_t RST_STATE = CLEAR_ON_RESET ? CLEAR : RUN;
    state_t state, state_nxt;
    logic [AW-3:0] clr_addr, addr_q;
    logic run, clr, gnt_a, gnt_b;
    // Gating with RESETn keeps READY and M_WREN low while reset is held.
    assign run = RESETn && state == RUN;
    assign clr = RESETn && state == CLEAR;
    assign A_RDATA = M_RDATA;
    assign B_RDATA = M_RDATA;
    rr_arb2 u_arb (
        .CLK   (CLK),
        .RESETn(RESETn),
        .en    (run),
        .req_a (A_VALID),
        .req_b (B_VALID),
        .upd   (gnt_a | gnt_b),
        .gnt_a (gnt_a),
        .gnt_b (gnt_b)
    );
    always_comb begin
        state_nxt = (clr && clr_addr == '1) ? RUN : state;
        A_READY = gnt_a;
        B_READY = gnt_b;
        M_ADDR = clr ? clr_addr : gnt_a ? A_ADDR : gnt_b ? B_ADDR : addr_q;
        M_WDATA = gnt_b ? B_WDATA : '0;
        M_WREN = clr ? WREN_ALL : (gnt_b && B_WRITE) ? B_WSTRB : '0;
    end
    always_ff @(posedge CLK or negedge RESETn)
        if (!RESETn) begin
            state <= RST_STATE;
            clr_addr <= '0;
            addr_q <= '0;
            A_RVALID <= 1'b0;
            B_RVALID <= 1'b0;
            INIT_DONE <= ~CLEAR_ON_RESET;
        end else begin
            state <= state_nxt;
            clr_addr <= (clr && clr_addr != '1) ? clr_addr + 1'b1 : clr_addr;
            addr_q <= M_ADDR;
            A_RVALID <= gnt_a;
            B_RVALID <= gnt_b;
            INIT_DONE <= state_nxt == RUN;
        end
endmodule
